frame_receiver: RTL and testbench
=================================

Name: frame_receiver

Overview:
Serial frame receiver at the far end of the 1-bit framed link driven by the team's transmitter. It accepts a qualified bit stream (rxIn + rxValid) and an abort strobe, and deserializes a fixed-length frame MSB-first into WORD_W-bit words. It reports frame completion or frame error to the downstream consumer. It sits between the link pins and the word-level buffer.

Parameters:
FRAME_LEN, 96, bits per frame; must be a multiple of WORD_W and < 2**CNT_W
WORD_W, 8, bits per output word
CNT_W, 7, width of the bit counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
rxIn  input  1  serial data bit; line idles high
rxValid  input  1  rxIn carries a frame bit this cycle
rxAbort  input  1  sender aborted the current frame
dataOut  output  WORD_W  last completed word, MSB = first-received bit
dataValid  output  1  one-cycle pulse: dataOut holds a new word
frameDone  output  1  one-cycle pulse: FRAME_LEN bits received cleanly
frameError  output  1  one-cycle pulse: frame aborted or broken by a gap
busy  output  1  high while in Receive
bitCount  output  CNT_W  bits accepted in current frame; 0 outside Receive

Behaviour:
- Reset (rst=0, async): state=Idle; dataOut=0, dataValid=0, frameDone=0, frameError=0, busy=0, bitCount=0, shift register and word-bit counter cleared. Reset mid-frame discards all partial data and produces no pulses.
- All outputs registered; every sampled event is reflected on outputs the following cycle.
- States: Idle, Receive, Done, Error.
- Idle: rxAbort ignored. On rxValid=1: sample rxIn as bit 1, bitCount<=1, go to Receive.
- Receive, priority order:
  1. rxAbort=1 -> Error. rxAbort wins over rxValid, including on the final bit.
  2. rxValid=0 -> Error (gap before FRAME_LEN bits).
  3. Otherwise shift rxIn into the LSB of the shift register and increment bitCount.
- Word completion: when the WORD_W-th bit of a word is sampled, dataOut <= {shift[WORD_W-2:0], rxIn} and dataValid=1 the next cycle. The word-bit counter wraps to 0.
- Frame completion: when the bit making bitCount==FRAME_LEN is sampled, go to Done. The final dataValid and frameDone pulse in the same cycle.
- Done: frameDone=1 for exactly one cycle, then Idle. rxValid and rxAbort are ignored in Done.
- Error: frameError=1 for exactly one cycle, then Idle. The partial word is discarded, dataOut keeps its previous value, and no dataValid is issued. Inputs are ignored in Error.
- Minimum gap between frames is 1 idle cycle (the Done/Error cycle). A frame whose first valid bit arrives in the Done/Error cycle is lost; the next rxValid in Idle starts a new frame.
- dataOut holds its value between pulses. frameDone and frameError are never high together.
- busy=1 exactly while state==Receive. bitCount returns to 0 on entry to Idle.

Test Plan:
- Reset, then 96 consecutive valid bits of repeating 0xA5 pattern -> 12 dataValid pulses each 0xA5, one every 8 cycles; frameDone pulses with the 12th; busy low after; bitCount back to 0.
- Frame of bytes 0x00..0x0B, rxAbort asserted together with bit 41 -> exactly 5 dataValid (0x00..0x04), frameError one cycle later, no frameDone, dataOut stays 0x04.
- rxValid dropped for 1 cycle after bit 20 -> frameError next cycle, 2 dataValid only. A fresh 96-bit frame afterwards completes with frameDone.
- rst=0 asynchronously mid-frame at bit 50 -> all outputs 0 immediately. After release, a full frame of 0xFF -> 12 words of 0xFF, frameDone.
- Two back-to-back frames separated by exactly 1 idle cycle (0x3C pattern, then 0xC3) -> 24 dataValid, two frameDone pulses, no frameError.
- rxAbort pulses in Idle, and a 96th bit arriving with rxAbort=1 -> no pulses in Idle; frameError (not frameDone) for the second case.

Source files
------------

// File: rtl/frame_receiver.sv
// Serial frame receiver: deserializes a qualified MSB-first bit stream into words
// and reports clean frame completion or abort/gap errors with one-cycle pulses.
//
// state   | meaning
// IDLE    | waiting for the first valid bit of a frame
// RECEIVE | accepting bits; any abort or gap ends the frame as an error
// DONE    | FRAME_LEN bits received cleanly; frameDone high this cycle
// ERROR   | frame aborted or broken by a gap; frameError high this cycle
module frame_receiver #(
    parameter int FRAME_LEN = 96,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxIn,
    input  logic              rxValid,
    input  logic              rxAbort,
    output logic [WORD_W-1:0] dataOut,
    output logic              dataValid,
    output logic              frameDone,
    output logic              frameError,
    output logic              busy,
    output logic [CNT_W-1:0]  bitCount
);

    localparam int WB_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t state, state_nx;

    // Only WORD_W-1 bits need storing: the last bit of a word goes straight to dataOut.
    logic [WORD_W-2:0] shift_q, shift_nx;
    logic [WB_W-1:0]   wcnt_q, wcnt_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic [WORD_W-1:0] data_nx;
    logic              valid_nx;

    always_comb begin
        state_nx = state;
        shift_nx = shift_q;
        wcnt_nx  = wcnt_q;
        cnt_nx   = bitCount;
        data_nx  = dataOut;
        valid_nx = 1'b0;

        case (state)
            IDLE: begin
                cnt_nx  = '0;
                wcnt_nx = '0;
                if (rxValid) begin
                    shift_nx = {shift_q[WORD_W-3:0], rxIn};
                    wcnt_nx  = WB_W'(1);
                    cnt_nx   = CNT_W'(1);
                    state_nx = RECEIVE;
                end
            end

            RECEIVE: begin
                if (rxAbort || !rxValid) begin
                    state_nx = ERROR;
                    cnt_nx   = '0;
                    wcnt_nx  = '0;
                end else begin
                    shift_nx = {shift_q[WORD_W-3:0], rxIn};
                    if (wcnt_q == WB_W'(WORD_W - 1)) begin
                        data_nx  = {shift_q, rxIn};
                        valid_nx = 1'b1;
                        wcnt_nx  = '0;
                    end else begin
                        wcnt_nx = wcnt_q + WB_W'(1);
                    end
                    if (bitCount == CNT_W'(FRAME_LEN - 1)) begin
                        state_nx = DONE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = bitCount + CNT_W'(1);
                    end
                end
            end

            DONE, ERROR: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                wcnt_nx  = '0;
            end

            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                wcnt_nx  = '0;
            end
        endcase
    end

    // Status pulses are registered from the next state so they align with the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            wcnt_q     <= '0;
            bitCount   <= '0;
            dataOut    <= '0;
            dataValid  <= 1'b0;
            frameDone  <= 1'b0;
            frameError <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_q    <= shift_nx;
            wcnt_q     <= wcnt_nx;
            bitCount   <= cnt_nx;
            dataOut    <= data_nx;
            dataValid  <= valid_nx;
            frameDone  <= (state_nx == DONE);
            frameError <= (state_nx == ERROR);
            busy       <= (state_nx == RECEIVE);
        end
    end

endmodule

// File: tb/tb_frame_receiver.sv
// Scoreboard bench for frame_receiver: the driver queues expected words and frame
// events with their expected cycle; a negedge monitor pops and compares them.
module tb_frame_receiver;

    localparam int FRAME_LEN = 96;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rxIn = 1'b1;
    logic              rxValid = 1'b0;
    logic              rxAbort = 1'b0;
    logic [WORD_W-1:0] dataOut;
    logic              dataValid;
    logic              frameDone;
    logic              frameError;
    logic              busy;
    logic [CNT_W-1:0]  bitCount;

    frame_receiver #(
        .FRAME_LEN(FRAME_LEN),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxIn      (rxIn),
        .rxValid   (rxValid),
        .rxAbort   (rxAbort),
        .dataOut   (dataOut),
        .dataValid (dataValid),
        .frameDone (frameDone),
        .frameError(frameError),
        .busy      (busy),
        .bitCount  (bitCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = word, 1 = frameDone, 2 = frameError
    typedef struct {
        int         cyc;
        logic [7:0] data;
        int         kind;
    } ev_t;

    ev_t word_q[$];
    ev_t frm_q[$];

    int total = 0;
    int bad   = 0;

    logic [7:0] fb [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (rst) begin
            if (frameDone && frameError) begin
                total++; bad++;
                $display("FAIL done_and_error: both high at cycle %0d", cyc);
            end
            if (dataValid) begin
                if (word_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_word: got 0x%0h at cycle %0d expected none", dataOut, cyc);
                end else begin
                    e = word_q.pop_front();
                    chk("word_data", dataOut, e.data);
                    chk("word_cycle", cyc, e.cyc);
                end
            end
            if (frameDone || frameError) begin
                k = frameDone ? 1 : 2;
                if (frm_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame_event: got kind %0d at cycle %0d expected none", k, cyc);
                end else begin
                    e = frm_q.pop_front();
                    chk("frame_kind", k, e.kind);
                    chk("frame_cycle", cyc, e.cyc);
                end
            end
            while (word_q.size() > 0 && word_q[0].cyc < cyc) begin
                e = word_q.pop_front();
                total++; bad++;
                $display("FAIL missing_word: got nothing expected 0x%0h at cycle %0d", e.data, e.cyc);
            end
            while (frm_q.size() > 0 && frm_q[0].cyc < cyc) begin
                e = frm_q.pop_front();
                total++; bad++;
                $display("FAIL missing_frame_event: got nothing expected kind %0d at cycle %0d", e.kind, e.cyc);
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            rxIn    = 1'b1;
            rxValid = 1'b0;
            rxAbort = 1'b0;
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 12; i++) fb[i] = v;
    endtask

    // abort_at / gap_after / stop_at: 0 means "not used"
    task automatic send_frame(input int abort_at, input int gap_after, input int stop_at);
        for (int n = 1; n <= FRAME_LEN; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                chk("bitcount_run", bitCount, n - 1);
                chk("busy_run", busy, 1);
            end
            if (gap_after > 0 && n == gap_after + 1) begin
                rxIn    = 1'b1;
                rxValid = 1'b0;
                rxAbort = 1'b0;
                frm_q.push_back('{cyc + 1, 8'h00, 2});
                return;
            end
            rxIn    = fb[(n-1)/8][7-((n-1)%8)];
            rxValid = 1'b1;
            rxAbort = (n == abort_at);
            if (n == abort_at) begin
                frm_q.push_back('{cyc + 1, 8'h00, 2});
                return;
            end
            if (n % 8 == 0) word_q.push_back('{cyc + 1, fb[n/8-1], 0});
            if (n == FRAME_LEN) frm_q.push_back('{cyc + 1, 8'h00, 1});
            if (n == stop_at) return;
        end
    endtask

    task automatic check_quiet(input string tag, input logic [7:0] exp_data);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bitcount"}, bitCount, 0);
        chk({tag, "_dataout"}, dataOut, exp_data);
        chk({tag, "_pending"}, word_q.size() + frm_q.size(), 0);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_dataout", dataOut, 0);
        chk("rst_datavalid", dataValid, 0);
        chk("rst_framedone", frameDone, 0);
        chk("rst_frameerror", frameError, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bitcount", bitCount, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // full frame of 0xA5
        fill(8'hA5);
        send_frame(0, 0, 0);
        idle(3);
        check_quiet("t1", 8'hA5);

        // abort together with bit 41
        for (int i = 0; i < 12; i++) fb[i] = 8'(i);
        send_frame(41, 0, 0);
        idle(3);
        check_quiet("t2", 8'h04);

        // gap after bit 20, then a fresh clean frame
        send_frame(0, 20, 0);
        idle(3);
        check_quiet("t3a", 8'h01);
        for (int i = 0; i < 12; i++) fb[i] = 8'(8'h10 + i);
        send_frame(0, 0, 0);
        idle(3);
        check_quiet("t3b", 8'h1B);

        // async reset mid-frame at bit 50
        fill(8'hFF);
        send_frame(0, 0, 50);
        #6;
        chk("t4_pre_bitcount", bitCount, 50);
        chk("t4_pre_dataout", dataOut, 8'hFF);
        rst = 1'b0;
        #1;
        chk("t4_rst_dataout", dataOut, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_bitcount", bitCount, 0);
        chk("t4_rst_pulses", {dataValid, frameDone, frameError}, 0);
        rxValid = 1'b0;
        rxIn    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        send_frame(0, 0, 0);
        idle(3);
        check_quiet("t4", 8'hFF);

        // back-to-back frames with one idle cycle between
        fill(8'h3C);
        send_frame(0, 0, 0);
        idle(1);
        fill(8'hC3);
        send_frame(0, 0, 0);
        idle(3);
        check_quiet("t5", 8'hC3);

        // aborts in Idle are ignored; abort on the 96th bit gives an error
        repeat (5) begin
            @(negedge clk);
            rxIn    = 1'b1;
            rxValid = 1'b0;
            rxAbort = 1'b1;
        end
        idle(2);
        check_quiet("t6a", 8'hC3);
        fill(8'h96);
        send_frame(96, 0, 0);
        idle(3);
        check_quiet("t6b", 8'h96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
